sram_write_req_queue: RTL and testbench

Buffers completed scratchpad write requests produced by the SRAM write latch and issues them, in order, to the scratchpad SRAM write port using a valid/ready handshake. It sits directly downstream of the write latch. It drives the latch's `be_stall` input so that a latched request is never dropped while the SRAM bank is back-pressured. Storage is a DEPTH-entry circular FIFO with an occupancy counter, a flush input and a sticky overflow flag.

---
 rtl/sram_write_req_queue.sv | 108 ++++++++++
 tb/tb_sram_write_req_queue.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/sram_write_req_queue.sv
// In-order FIFO between the SRAM write latch and the scratchpad SRAM write port.
// Raises be_stall early enough that a latched write request is never lost under back-pressure.
package scpad_pkg;
    typedef struct packed {
        logic [9:0]  addr;
        logic [31:0] wdata;
    } sram_write_req_t;
endpackage

module sram_write_req_queue #(
    parameter int DEPTH        = 4,
    parameter int STALL_MARGIN = 1,
    parameter int REQ_W        = $bits(scpad_pkg::sram_write_req_t)
) (
    input  logic                       CLK,
    input  logic                       nRST,
    input  logic [REQ_W-1:0]           req_in,
    input  logic                       req_in_valid,
    output logic                       be_stall,
    output logic [REQ_W-1:0]           sram_wr_req,
    output logic                       sram_wr_valid,
    input  logic                       sram_wr_ready,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] occupancy,
    output logic                       overflow_err,
    output logic                       idle
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] MARGIN_C = CW'(STALL_MARGIN);

    logic [REQ_W-1:0] mem_r [DEPTH];
    logic [PW-1:0]    wptr_r;
    logic [PW-1:0]    rptr_r;
    logic [CW-1:0]    count_r;
    logic             overflow_r;

    logic             pop_s;
    logic             push_ok_s;
    logic             drop_s;
    logic             wr_en_s;
    logic [CW-1:0]    free_s;

    // Handshake decode; a full queue still accepts a push when the head leaves this cycle.
    always_comb begin
        pop_s     = 1'b0;
        push_ok_s = 1'b0;
        drop_s    = 1'b0;
        wr_en_s   = 1'b0;
        free_s    = DEPTH_C - count_r;
        pop_s     = (count_r != {CW{1'b0}}) & sram_wr_ready;
        push_ok_s = req_in_valid & ((count_r != DEPTH_C) | pop_s);
        drop_s    = req_in_valid & ~push_ok_s;
        if (flush || !nRST) begin
            wr_en_s = 1'b0;
        end else begin
            wr_en_s = push_ok_s;
        end
    end

    // Payload storage; contents are left unreset since pointers define validity.
    always_ff @(posedge CLK) begin
        if (wr_en_s) begin
            mem_r[wptr_r] <= req_in;
        end
    end

    // Pointers, occupancy and sticky overflow; flush outranks any concurrent push or pop.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            wptr_r     <= {PW{1'b0}};
            rptr_r     <= {PW{1'b0}};
            count_r    <= {CW{1'b0}};
            overflow_r <= 1'b0;
        end else if (flush) begin
            wptr_r     <= {PW{1'b0}};
            rptr_r     <= {PW{1'b0}};
            count_r    <= {CW{1'b0}};
            overflow_r <= 1'b0;
        end else begin
            if (push_ok_s) begin
                wptr_r <= wptr_r + {{(PW-1){1'b0}}, 1'b1};
            end
            if (pop_s) begin
                rptr_r <= rptr_r + {{(PW-1){1'b0}}, 1'b1};
            end
            if (push_ok_s && !pop_s) begin
                count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
            end else if (pop_s && !push_ok_s) begin
                count_r <= count_r - {{(CW-1){1'b0}}, 1'b1};
            end
            if (drop_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // Output decode is purely from registered state (idle also looks at the incoming pulse).
    always_comb begin
        sram_wr_valid = (count_r != {CW{1'b0}});
        sram_wr_req   = mem_r[rptr_r];
        be_stall      = (free_s <= MARGIN_C);
        occupancy     = count_r;
        overflow_err  = overflow_r;
        idle          = (count_r == {CW{1'b0}}) & ~req_in_valid;
    end
endmodule

// File: tb/tb_sram_write_req_queue.sv
// Bench for sram_write_req_queue: directed vector table, wrap-around stream and a randomized run
// checked against a queue-based reference model.
module tb_sram_write_req_queue;
    localparam int DEPTH        = 4;
    localparam int STALL_MARGIN = 1;
    localparam int REQ_W        = $bits(scpad_pkg::sram_write_req_t);
    localparam int CW           = $clog2(DEPTH + 1);

    logic             CLK = 1'b0;
    logic             nRST;
    logic [REQ_W-1:0] req_in;
    logic             req_in_valid;
    logic             be_stall;
    logic [REQ_W-1:0] sram_wr_req;
    logic             sram_wr_valid;
    logic             sram_wr_ready;
    logic             flush;
    logic [CW-1:0]    occupancy;
    logic             overflow_err;
    logic             idle;

    int checks = 0;
    int errors = 0;

    sram_write_req_queue #(.DEPTH(DEPTH), .STALL_MARGIN(STALL_MARGIN)) dut (
        .CLK(CLK), .nRST(nRST), .req_in(req_in), .req_in_valid(req_in_valid),
        .be_stall(be_stall), .sram_wr_req(sram_wr_req), .sram_wr_valid(sram_wr_valid),
        .sram_wr_ready(sram_wr_ready), .flush(flush), .occupancy(occupancy),
        .overflow_err(overflow_err), .idle(idle)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic             nrst;
        logic             vld;
        logic [REQ_W-1:0] data;
        logic             rdy;
        logic             fl;
        int               occ;
        logic             ev;
        logic [REQ_W-1:0] req;
        logic             es;
        logic             eo;
        logic             ei;
    } vec_t;

    vec_t             vq[$];
    logic [REQ_W-1:0] mq[$];
    logic             movf;
    logic [REQ_W-1:0] issued[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic addv(input logic nrst, input logic vld, input logic [REQ_W-1:0] data,
                        input logic rdy, input logic fl, input int occ, input logic ev,
                        input logic [REQ_W-1:0] req, input logic es, input logic eo,
                        input logic ei);
        vec_t v;
        v.nrst = nrst; v.vld = vld; v.data = data; v.rdy = rdy; v.fl = fl;
        v.occ = occ; v.ev = ev; v.req = req; v.es = es; v.eo = eo; v.ei = ei;
        vq.push_back(v);
    endtask

    // One clock with reference-model checks before the edge and model update at the edge.
    task automatic cycle(input logic nrst, input logic vld, input logic [REQ_W-1:0] data,
                         input logic rdy, input logic fl);
        logic pop;
        logic push_ok;
        nRST = nrst; req_in_valid = vld; req_in = data; sram_wr_ready = rdy; flush = fl;
        #1;
        chk("valid", 64'(sram_wr_valid), 64'(mq.size() != 0));
        if (mq.size() != 0) chk("head", 64'(sram_wr_req), 64'(mq[0]));
        chk("occupancy", 64'(occupancy), 64'(mq.size()));
        chk("be_stall", 64'(be_stall), 64'((DEPTH - mq.size()) <= STALL_MARGIN));
        chk("overflow", 64'(overflow_err), 64'(movf));
        chk("idle", 64'(idle), 64'(mq.size() == 0 && !vld));
        pop     = (mq.size() != 0) && rdy;
        push_ok = vld && (mq.size() < DEPTH || pop);
        if (pop && nrst && !fl) issued.push_back(mq[0]);
        @(posedge CLK);
        if (!nrst || fl) begin
            mq.delete();
            movf = 1'b0;
        end else begin
            if (pop) void'(mq.pop_front());
            if (push_ok) mq.push_back(data);
            if (vld && !push_ok) movf = 1'b1;
        end
        #1;
    endtask

    initial begin
        logic [REQ_W-1:0] pa, pb, pc, pd, pe, pf, pg, ph, pj, pk, z;
        int n;
        int guard;
        pa = 42'h0AA; pb = 42'h0BB; pc = 42'h0CC; pd = 42'h0DD; pe = 42'h0EE;
        pf = 42'h0FF; pg = 42'h111; ph = 42'h122; pj = 42'h133; pk = 42'h144; z = 42'h0;

        // nrst vld data rdy fl | occ ev req es eo ei
        addv(1'b0, 1'b0, z,  1'b0, 1'b0, 0, 1'b0, z,  1'b0, 1'b0, 1'b1);
        addv(1'b0, 1'b0, z,  1'b0, 1'b0, 0, 1'b0, z,  1'b0, 1'b0, 1'b1);
        addv(1'b1, 1'b0, z,  1'b0, 1'b0, 0, 1'b0, z,  1'b0, 1'b0, 1'b1);
        addv(1'b1, 1'b1, pa, 1'b1, 1'b0, 1, 1'b1, pa, 1'b0, 1'b0, 1'b0);
        addv(1'b1, 1'b0, z,  1'b1, 1'b0, 0, 1'b0, z,  1'b0, 1'b0, 1'b1);
        addv(1'b1, 1'b1, pa, 1'b0, 1'b0, 1, 1'b1, pa, 1'b0, 1'b0, 1'b0);
        addv(1'b1, 1'b1, pb, 1'b0, 1'b0, 2, 1'b1, pa, 1'b0, 1'b0, 1'b0);
        addv(1'b1, 1'b1, pc, 1'b0, 1'b0, 3, 1'b1, pa, 1'b1, 1'b0, 1'b0);
        addv(1'b1, 1'b1, pd, 1'b0, 1'b0, 4, 1'b1, pa, 1'b1, 1'b0, 1'b0);
        addv(1'b1, 1'b1, pe, 1'b0, 1'b0, 4, 1'b1, pa, 1'b1, 1'b1, 1'b0);
        addv(1'b1, 1'b1, pf, 1'b1, 1'b0, 4, 1'b1, pb, 1'b1, 1'b1, 1'b0);
        addv(1'b1, 1'b0, z,  1'b1, 1'b0, 3, 1'b1, pc, 1'b1, 1'b1, 1'b0);
        addv(1'b1, 1'b0, z,  1'b1, 1'b0, 2, 1'b1, pd, 1'b0, 1'b1, 1'b0);
        addv(1'b1, 1'b0, z,  1'b1, 1'b0, 1, 1'b1, pf, 1'b0, 1'b1, 1'b0);
        addv(1'b1, 1'b0, z,  1'b1, 1'b0, 0, 1'b0, z,  1'b0, 1'b1, 1'b1);
        addv(1'b1, 1'b1, pg, 1'b0, 1'b0, 1, 1'b1, pg, 1'b0, 1'b1, 1'b0);
        addv(1'b1, 1'b1, ph, 1'b0, 1'b0, 2, 1'b1, pg, 1'b0, 1'b1, 1'b0);
        addv(1'b1, 1'b1, pc, 1'b0, 1'b0, 3, 1'b1, pg, 1'b1, 1'b1, 1'b0);
        addv(1'b1, 1'b1, pj, 1'b1, 1'b1, 0, 1'b0, z,  1'b0, 1'b0, 1'b0);
        addv(1'b1, 1'b0, z,  1'b1, 1'b0, 0, 1'b0, z,  1'b0, 1'b0, 1'b1);
        addv(1'b1, 1'b1, pk, 1'b0, 1'b0, 1, 1'b1, pk, 1'b0, 1'b0, 1'b0);
        addv(1'b0, 1'b1, pa, 1'b1, 1'b0, 0, 1'b0, z,  1'b0, 1'b0, 1'b0);

        foreach (vq[i]) begin
            nRST = vq[i].nrst; req_in_valid = vq[i].vld; req_in = vq[i].data;
            sram_wr_ready = vq[i].rdy; flush = vq[i].fl;
            @(posedge CLK);
            #1;
            chk($sformatf("v%0d occupancy", i), 64'(occupancy), 64'(vq[i].occ));
            chk($sformatf("v%0d valid", i), 64'(sram_wr_valid), 64'(vq[i].ev));
            chk($sformatf("v%0d be_stall", i), 64'(be_stall), 64'(vq[i].es));
            chk($sformatf("v%0d overflow", i), 64'(overflow_err), 64'(vq[i].eo));
            chk($sformatf("v%0d idle", i), 64'(idle), 64'(vq[i].ei));
            if (vq[i].ev) chk($sformatf("v%0d head", i), 64'(sram_wr_req), 64'(vq[i].req));
        end

        // Model-tracked phase starts from a clean reset.
        movf = 1'b0;
        mq.delete();
        cycle(1'b0, 1'b0, z, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, z, 1'b0, 1'b0);
        issued.delete();

        // Wrap-around stream: the producer honours be_stall, ready toggles every cycle.
        n = 0;
        guard = 0;
        while (n < 10 && guard < 100) begin
            if (!be_stall) begin
                cycle(1'b1, 1'b1, REQ_W'(42'h500 + n), 1'(guard % 2 == 0), 1'b0);
                n++;
            end else begin
                cycle(1'b1, 1'b0, z, 1'(guard % 2 == 0), 1'b0);
            end
            guard++;
        end
        guard = 0;
        while (sram_wr_valid && guard < 20) begin
            cycle(1'b1, 1'b0, z, 1'b1, 1'b0);
            guard++;
        end
        chk("wrap issued count", 64'(issued.size()), 64'd10);
        for (int i = 0; i < 10; i++) begin
            if (i < issued.size()) chk($sformatf("wrap order %0d", i), 64'(issued[i]), 64'(42'h500 + i));
        end
        chk("wrap no overflow", 64'(overflow_err), 64'd0);

        // Randomized traffic with occasional flush and reset.
        for (int i = 0; i < 600; i++) begin
            cycle(1'($urandom_range(0, 49) != 0), 1'($urandom_range(0, 2) != 0),
                  REQ_W'({$urandom, $urandom}), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 39) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
